// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI burst sequencer.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  localparam int unsigned MAX_BURST = 8;

endpackage

// File: rtl/spi_burst_sequencer_if.sv
// Byte-level handshake between the burst sequencer and the downstream spi_master.
interface spi_burst_sequencer_if;

  logic [7:0] m_tx_data;
  logic       m_tx_vd;
  logic       m_tx_ready;
  logic [7:0] m_rx_data;
  logic       m_rx_valid;

  // Sequencer side: drives the transaction, consumes the master's pulses.
  modport master (
    output m_tx_data,
    output m_tx_vd,
    input  m_tx_ready,
    input  m_rx_data,
    input  m_rx_valid
  );

  // spi_master side.
  modport slave (
    input  m_tx_data,
    input  m_tx_vd,
    output m_tx_ready,
    output m_rx_data,
    output m_rx_valid
  );

endinterface

// File: rtl/spi_byte_fifo.sv
// Synchronous 8-bit first-word-fall-through FIFO; the head is visible on rd_data_o.
module spi_byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_en_i,
  output logic [7:0]               rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            push, pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign push    = wr_en_i & ~full_o;
  assign pop     = rd_en_i & ~empty_o;

  // Empty FIFO reads as zero so the head output has a defined reset value.
  assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Buffers host TX bytes and runs 1..8 byte bursts against spi_master, collecting RX bytes.
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         i_wr_en,
  input  logic [7:0]                   i_wr_data,
  input  logic                         i_start,
  input  logic [2:0]                   i_len,
  input  logic                         i_rd_en,
  output logic [7:0]                   o_rd_data,
  output logic                         o_tx_full,
  output logic [$clog2(FIFO_DEPTH):0]  o_tx_level,
  output logic                         o_rx_empty,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err,
  output logic [1:0]                   o_err_code,
  output logic                         o_rx_ovf,
  spi_burst_sequencer_if.master        m_if
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  seq_state_e      state_q, state_d;
  logic [2:0]      len_q, len_d;
  logic [CntW-1:0] sent_q, sent_d;
  logic [CntW-1:0] rxc_q, rxc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_vd_q, tx_vd_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            ovf_q, ovf_d;

  logic            tx_pop, rx_push;
  logic [7:0]      tx_rdata;
  logic            tx_empty, rx_full;
  logic [LvlW-1:0] need;
  logic [LvlW-1:0] unused_rx_level;

  assign need = LvlW'(i_len) + LvlW'(1);

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst),
    .wr_en_i   (i_wr_en),
    .wr_data_i (i_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_rdata),
    .full_o    (o_tx_full),
    .empty_o   (tx_empty),
    .level_o   (o_tx_level)
  );

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst),
    .wr_en_i   (rx_push),
    .wr_data_i (m_if.m_rx_data),
    .rd_en_i   (i_rd_en),
    .rd_data_o (o_rd_data),
    .full_o    (rx_full),
    .empty_o   (o_rx_empty),
    .level_o   (unused_rx_level)
  );

  // Burst FSM: next state, counters, FIFO pops/pushes and status pulses.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sent_d    = sent_q;
    rxc_d     = rxc_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    tx_vd_d   = tx_vd_q;
    err_d     = 1'b0;
    code_d    = code_q;
    ovf_d     = ovf_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (o_tx_level >= need) begin
            len_d   = i_len;
            state_d = LOAD;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_UNDERFLOW;
          end
        end
      end
      LOAD: begin
        tx_pop    = 1'b1;
        tx_data_d = tx_rdata;
        sent_d    = CntW'(1);
        rxc_d     = '0;
        tmo_d     = '0;
        tx_vd_d   = 1'b1;
        state_d   = XFER;
      end
      XFER: begin
        // Once every byte of the burst is out, further ready pulses leave the data alone.
        if (m_if.m_tx_ready && (sent_q <= {1'b0, len_q}) && !tx_empty) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_rdata;
          sent_d    = sent_q + CntW'(1);
        end
        if (m_if.m_rx_valid) begin
          // A dropped byte still counts so the burst always terminates.
          if (rx_full) begin
            ovf_d = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
          rxc_d = rxc_q + CntW'(1);
          tmo_d = '0;
          if (rxc_q == {1'b0, len_q}) begin
            tx_vd_d = 1'b0;
            state_d = DONE;
          end
        end else if (tmo_q == TmoMax) begin
          tx_vd_d = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sent_q    <= '0;
      rxc_q     <= '0;
      tmo_q     <= '0;
      tx_data_q <= '0;
      tx_vd_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sent_q    <= sent_d;
      rxc_q     <= rxc_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      tx_vd_q   <= tx_vd_d;
      err_q     <= err_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);
  assign o_err          = err_q;
  assign o_err_code     = code_q;
  assign o_rx_ovf       = ovf_q;
  assign m_if.m_tx_data = tx_data_q;
  assign m_if.m_tx_vd   = tx_vd_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a hand-driven spi_master model.
module tb_spi_burst_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 1024;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_start = 1'b0;
  logic [2:0] i_len = 3'd0;
  logic       i_rd_en = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_tx_full;
  logic [3:0] o_tx_level;
  logic       o_rx_empty;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_rx_ovf;

  spi_burst_sequencer_if m_if ();

  spi_burst_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_rd_en    (i_rd_en),
    .o_rd_data  (o_rd_data),
    .o_tx_full  (o_tx_full),
    .o_tx_level (o_tx_level),
    .o_rx_empty (o_rx_empty),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_rx_ovf   (o_rx_ovf),
    .m_if       (m_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  logic [7:0] exp_tx [8];
  logic [7:0] rx_vals [8];

  always @(negedge sys_clk) begin
    if (o_done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    i_wr_en = 1'b0;
    i_start = 1'b0;
    i_rd_en = 1'b0;
    m_if.m_tx_ready = 1'b0;
    m_if.m_rx_valid = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] d);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic pop_check(input logic [7:0] exp);
    check_eq("rx_data", 32'(o_rd_data), 32'(exp));
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
  endtask

  // One ready + valid pulse from the master model.
  task automatic master_pulse(input logic [7:0] rx);
    m_if.m_tx_ready = 1'b1;
    m_if.m_rx_valid = 1'b1;
    m_if.m_rx_data  = rx;
    tick();
    m_if.m_tx_ready = 1'b0;
    m_if.m_rx_valid = 1'b0;
  endtask

  // Start a burst and wait (bounded) for the transaction valid to rise.
  task automatic start_burst(input logic [2:0] len);
    int w;
    i_start = 1'b1;
    i_len   = len;
    tick();
    i_start = 1'b0;
    w = 0;
    while (!m_if.m_tx_vd && w < 8) begin
      tick();
      w++;
    end
    check_eq("vd_latency", 32'(w), 32'd1);
  endtask

  task automatic do_burst(input logic [2:0] len);
    start_burst(len);
    for (int i = 0; i <= int'(len); i++) begin
      check_eq("tx_byte", 32'(m_if.m_tx_data), 32'(exp_tx[i]));
      master_pulse(rx_vals[i]);
    end
    check_eq("done_pulse", 32'(o_done), 32'd1);
    check_eq("vd_drop", 32'(m_if.m_tx_vd), 32'd0);
  endtask

  initial begin
    int base;
    int cnt;
    m_if.m_tx_ready = 1'b0;
    m_if.m_rx_valid = 1'b0;
    m_if.m_rx_data  = 8'h00;

    // Reset values
    #1;
    check_eq("rst_vd", 32'(m_if.m_tx_vd), 32'd0);
    check_eq("rst_rx_empty", 32'(o_rx_empty), 32'd1);
    check_eq("rst_level", 32'(o_tx_level), 32'd0);
    check_eq("rst_flags", 32'({o_tx_full, o_busy, o_done, o_err, o_err_code, o_rx_ovf}), 32'd0);
    do_reset();

    // 1: two-byte burst
    push(8'hA5);
    push(8'h3C);
    check_eq("t1_level_pre", 32'(o_tx_level), 32'd2);
    exp_tx[0] = 8'hA5; exp_tx[1] = 8'h3C;
    rx_vals[0] = 8'h11; rx_vals[1] = 8'h22;
    base = done_cnt;
    do_burst(3'd1);
    tick();
    check_eq("t1_done_once", 32'(done_cnt - base), 32'd1);
    check_eq("t1_idle", 32'(o_busy), 32'd0);
    check_eq("t1_level", 32'(o_tx_level), 32'd0);
    pop_check(8'h11);
    pop_check(8'h22);
    check_eq("t1_rx_empty", 32'(o_rx_empty), 32'd1);

    // 2: underflow reject
    do_reset();
    push(8'hB1);
    push(8'hB2);
    i_start = 1'b1;
    i_len   = 3'd3;
    tick();
    i_start = 1'b0;
    check_eq("t2_err", 32'(o_err), 32'd1);
    check_eq("t2_code", 32'(o_err_code), 32'd1);
    check_eq("t2_busy", 32'(o_busy), 32'd0);
    tick();
    check_eq("t2_err_pulse", 32'(o_err), 32'd0);
    check_eq("t2_code_hold", 32'(o_err_code), 32'd1);
    check_eq("t2_vd", 32'(m_if.m_tx_vd), 32'd0);
    check_eq("t2_level", 32'(o_tx_level), 32'd2);

    // 3: timeout after three of eight bytes
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    check_eq("t3_full", 32'(o_tx_full), 32'd1);
    start_burst(3'd7);
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_tx_byte", 32'(m_if.m_tx_data), 32'(8'h40 + 8'(i)));
      master_pulse(8'h90 + 8'(i));
    end
    cnt = 0;
    while (!o_err && cnt < int'(TMO) + 16) begin
      tick();
      cnt++;
    end
    check_eq("t3_tmo_cycles", 32'(cnt), 32'(TMO));
    check_eq("t3_code", 32'(o_err_code), 32'd2);
    check_eq("t3_vd", 32'(m_if.m_tx_vd), 32'd0);
    check_eq("t3_busy", 32'(o_busy), 32'd0);
    check_eq("t3_level", 32'(o_tx_level), 32'd4);
    for (int i = 0; i < 3; i++) pop_check(8'h90 + 8'(i));
    check_eq("t3_rx_empty", 32'(o_rx_empty), 32'd1);

    // 4: RX overflow
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push(8'h50 + 8'(i));
      exp_tx[i]  = 8'h50 + 8'(i);
      rx_vals[i] = 8'h60 + 8'(i);
    end
    do_burst(3'd6);
    tick();
    check_eq("t4_no_ovf_yet", 32'(o_rx_ovf), 32'd0);
    push(8'h71);
    push(8'h72);
    exp_tx[0] = 8'h71; exp_tx[1] = 8'h72;
    rx_vals[0] = 8'hAA; rx_vals[1] = 8'hBB;
    base = done_cnt;
    do_burst(3'd1);
    check_eq("t4_ovf", 32'(o_rx_ovf), 32'd1);
    tick();
    tick();
    check_eq("t4_done_once", 32'(done_cnt - base), 32'd1);
    for (int i = 0; i < 7; i++) pop_check(8'h60 + 8'(i));
    pop_check(8'hAA);
    check_eq("t4_rx_empty", 32'(o_rx_empty), 32'd1);
    check_eq("t4_ovf_sticky", 32'(o_rx_ovf), 32'd1);

    // 5: reset mid-burst
    do_reset();
    push(8'hE1);
    push(8'hE2);
    push(8'hE3);
    start_burst(3'd2);
    master_pulse(8'hF1);
    check_eq("t5_busy_pre", 32'(o_busy), 32'd1);
    sys_rst = 1'b0;
    #1;
    check_eq("t5_vd", 32'(m_if.m_tx_vd), 32'd0);
    check_eq("t5_tx_data", 32'(m_if.m_tx_data), 32'd0);
    check_eq("t5_busy", 32'(o_busy), 32'd0);
    check_eq("t5_level", 32'(o_tx_level), 32'd0);
    check_eq("t5_rx_empty", 32'(o_rx_empty), 32'd1);
    check_eq("t5_rd_data", 32'(o_rd_data), 32'd0);
    tick();
    sys_rst = 1'b1;
    tick();
    push(8'h5A);
    exp_tx[0] = 8'h5A;
    rx_vals[0] = 8'hC3;
    do_burst(3'd0);
    tick();
    pop_check(8'hC3);

    // 6: host push in the same cycle as the LOAD pop
    do_reset();
    push(8'hC7);
    i_start = 1'b1;
    i_len   = 3'd0;
    tick();
    i_start = 1'b0;
    i_wr_en   = 1'b1;
    i_wr_data = 8'hD8;
    tick();
    i_wr_en = 1'b0;
    check_eq("t6_level", 32'(o_tx_level), 32'd1);
    check_eq("t6_tx_byte", 32'(m_if.m_tx_data), 32'hC7);
    master_pulse(8'h01);
    check_eq("t6_done", 32'(o_done), 32'd1);
    tick();
    exp_tx[0] = 8'hD8;
    rx_vals[0] = 8'h02;
    do_burst(3'd0);
    tick();
    check_eq("t6_level_end", 32'(o_tx_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Host-side stage directly upstream of spi_master. It buffers host TX bytes in a small FIFO and runs a burst of 1..8 bytes on command. During the burst it holds the master's transaction-valid input high and presents each next byte when the master requests it. Each byte the master receives goes into an RX FIFO for the host, and the block reports done, error and timeout status.

Parameters:
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of 2, minimum 8.
TIMEOUT_CYC, 1024, sys_clk cycles allowed between successive m_rx_valid pulses in XFER before abort.

Ports:
sys_clk  in  1  system clock.
sys_rst  in  1  reset; asynchronous, active-low.
i_wr_en  in  1  host push into TX FIFO; ignored when o_tx_full is high.
i_wr_data  in  8  byte pushed into the TX FIFO.
i_start  in  1  single-cycle burst request.
i_len  in  3  burst length minus 1 (0 means 1 byte, 7 means 8 bytes); sampled with i_start.
i_rd_en  in  1  host pop from RX FIFO; ignored when o_rx_empty is high.
o_rd_data  out  8  head of RX FIFO; shows the head entry (first-word-fall-through).
o_tx_full  out  1  TX FIFO is full.
o_tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
o_rx_empty  out  1  RX FIFO is empty.
o_busy  out  1  FSM is not in IDLE.
o_done  out  1  one-cycle pulse when a burst completes normally.
o_err  out  1  one-cycle pulse on a rejected start or on a timeout.
o_err_code  out  2  valid with o_err: 01 = underflow reject, 10 = timeout; holds its value until the next o_err.
o_rx_ovf  out  1  sticky; sets when an RX byte is dropped; cleared only by reset.
m_tx_data  out  8  byte to master (i_tx_parallel).
m_tx_vd  out  1  transaction valid to master (i_tx_vd).
m_tx_ready  in  1  master ready for next byte (o_tx_slv_ready); one-cycle pulse.
m_rx_data  in  8  received byte from master (o_rx_parallel).
m_rx_valid  in  1  received byte valid (o_tx_device_ready); one-cycle pulse.

Behaviour:
- Reset values: all outputs 0, except o_rx_empty = 1. Both FIFOs are emptied, the FSM goes to IDLE and all counters clear.
- Reset asserted mid-burst: m_tx_vd drops asynchronously and buffered data is lost.
- FSM states: IDLE, LOAD, XFER, DONE.
- IDLE, i_start=1, o_tx_level >= i_len+1: latch len; go to LOAD.
- IDLE, i_start=1, o_tx_level < i_len+1: o_err=1 with code 01 on the next cycle; stay in IDLE; FIFO untouched.
- i_start outside IDLE: ignored, no error.
- LOAD (1 cycle): pop the TX head into m_tx_data; set sent_cnt=1, rx_cnt=0; assert m_tx_vd. m_tx_vd is therefore high 2 cycles after i_start.
- XFER, m_tx_ready=1 and sent_cnt <= len: pop the next byte into m_tx_data on that edge; sent_cnt++.
- XFER, m_tx_ready=1 and sent_cnt > len: m_tx_data holds its value; no pop.
- XFER, m_rx_valid=1: push m_rx_data into the RX FIFO; rx_cnt++; reset the timeout counter.
- XFER, m_rx_valid=1 and rx_cnt == len: deassert m_tx_vd on the next edge; go to DONE.
- DONE (1 cycle): o_done=1; return to IDLE.
- Timeout: the counter runs only in XFER. When it reaches TIMEOUT_CYC-1: drop m_tx_vd; o_err=1 with code 10; return to IDLE.
- On timeout, unsent TX bytes of the burst stay in the TX FIFO. Bytes already received stay in the RX FIFO.
- RX FIFO full when m_rx_valid=1: the byte is dropped and o_rx_ovf sets. rx_cnt still increments, so the burst still terminates.
- Same-cycle events:
  - Host i_wr_en plus internal pop is allowed; level is unchanged.
  - Host i_rd_en plus internal push is allowed.
  - m_tx_ready plus m_rx_valid in the same cycle: both are processed.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. Full/empty come from an extra occupancy bit.
- Host writes while a burst is in progress are allowed; they are queued behind the current burst's bytes.

Decomposition:
- Package spi_seq_pkg:
  - state enum: IDLE=2'd0, LOAD=2'd1, XFER=2'd2, DONE=2'd3;
  - ERR_UNDERFLOW=2'b01, ERR_TIMEOUT=2'b10;
  - MAX_BURST=8.
- Sub-module spi_byte_fifo: synchronous 8-bit first-word-fall-through FIFO with full, empty and level outputs. Instantiated twice, for TX and RX.

Test Plan:
1. Push A5,3C; start with i_len=1; model the master's ready/valid pulses returning 11,22 -> m_tx_data shows A5 then 3C; o_done pulses once; RX FIFO reads 11,22; o_tx_level=0.
2. Push 2 bytes; start with i_len=3 -> o_err=1 with code 01 one cycle later; m_tx_vd never rises; o_tx_level stays 2.
3. Push 8 bytes; start with i_len=7; master model stops pulsing m_rx_valid after 3 bytes -> after TIMEOUT_CYC cycles, o_err code 10; m_tx_vd=0; RX holds 3 bytes; TX level=4 (1 loaded + 3 popped on ready pulses).
4. Fill the RX FIFO to FIFO_DEPTH-1; run a 2-byte burst -> first byte stored, second dropped; o_rx_ovf=1 and stays 1; o_done still pulses.
5. Assert reset in XFER after 1 byte -> all outputs at reset values immediately; a new 1-byte burst afterwards completes normally.
6. Assert i_wr_en on the same cycle as the LOAD pop with level=1 -> level stays 1; the pushed byte is transmitted by the next burst.
